bpu: RTL and testbench

BPU -- requirements
Module: bpu

---
 rtl/bpu.sv | 94 +++++++++
 tb/tb_bpu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bpu.sv
// Bimodal branch predictor: PHT of 2-bit counters; define BPU_GSHARE_EN to XOR a global history into the index.
// Latency: one cycle from request to registered prediction; an update bypasses into a same-cycle lookup.
// Backpressure: bpu_stall_in freezes the output registers; PHT updates are always applied.
module bpu #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_BITS   = 6
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  bpu_req_valid_in,
    input  logic [DATA_WIDTH-1:0] bpu_pc_in,
    input  logic                  bpu_stall_in,
    input  logic                  bpu_upd_valid_in,
    input  logic [IDX_BITS-1:0]   bpu_upd_idx_in,
    input  logic                  bpu_upd_taken_in,
    output logic                  bpu_valid_out,
    output logic                  bpu_prediction_out,
    output logic [IDX_BITS-1:0]   bpu_idx_out
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          pht [ENTRIES];
    logic [IDX_BITS-1:0] pc_idx;
    logic [IDX_BITS-1:0] lkp_idx;
    logic [1:0]          upd_cnt;
    logic [1:0]          upd_next;
    logic [1:0]          lkp_cnt;
    logic                lkp_pred;
    logic                unused_pc_bits;

    // Word-aligned PC: the low two bits and the bits above the index never matter.
    assign pc_idx         = bpu_pc_in[IDX_BITS+1:2];
    assign unused_pc_bits = ^{bpu_pc_in[DATA_WIDTH-1:IDX_BITS+2], bpu_pc_in[1:0]};

`ifdef BPU_GSHARE_EN
    logic [IDX_BITS-1:0] ghr;

    assign lkp_idx = pc_idx ^ ghr;

    // Lookups see the history before this cycle's update shifts in.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            ghr <= '0;
        end else if (bpu_upd_valid_in) begin
            ghr <= {ghr[IDX_BITS-2:0], bpu_upd_taken_in};
        end
    end
`else
    assign lkp_idx = pc_idx;
`endif

    always_comb begin
        upd_cnt  = pht[bpu_upd_idx_in];
        upd_next = upd_cnt;
        if (bpu_upd_taken_in) begin
            if (upd_cnt != 2'b11) begin
                upd_next = upd_cnt + 2'b01;
            end
        end else if (upd_cnt != 2'b00) begin
            upd_next = upd_cnt - 2'b01;
        end

        // Bypass the counter being written this cycle so the lookup sees its new value.
        lkp_cnt = pht[lkp_idx];
        if (bpu_upd_valid_in && (bpu_upd_idx_in == lkp_idx)) begin
            lkp_cnt = upd_next;
        end
        lkp_pred = bpu_req_valid_in & lkp_cnt[1];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (bpu_upd_valid_in) begin
            pht[bpu_upd_idx_in] <= upd_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bpu_valid_out      <= 1'b0;
            bpu_prediction_out <= 1'b0;
            bpu_idx_out        <= '0;
        end else if (!bpu_stall_in) begin
            bpu_valid_out      <= bpu_req_valid_in;
            bpu_prediction_out <= lkp_pred;
            bpu_idx_out        <= lkp_idx;
        end
    end

endmodule

// File: tb/tb_bpu.sv
// Bench for bpu: directed vector table, hand-written gshare sequence, and randomized traffic
// compared against a counter-array reference model.
module tb_bpu;

    localparam int DW = 32;
    localparam int IB = 6;
    localparam int N  = 1 << IB;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          bpu_req_valid_in;
    logic [DW-1:0] bpu_pc_in;
    logic          bpu_stall_in;
    logic          bpu_upd_valid_in;
    logic [IB-1:0] bpu_upd_idx_in;
    logic          bpu_upd_taken_in;
    logic          bpu_valid_out;
    logic          bpu_prediction_out;
    logic [IB-1:0] bpu_idx_out;

    always #5 clk_in = ~clk_in;

    bpu #(.DATA_WIDTH(DW), .IDX_BITS(IB)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .bpu_req_valid_in   (bpu_req_valid_in),
        .bpu_pc_in          (bpu_pc_in),
        .bpu_stall_in       (bpu_stall_in),
        .bpu_upd_valid_in   (bpu_upd_valid_in),
        .bpu_upd_idx_in     (bpu_upd_idx_in),
        .bpu_upd_taken_in   (bpu_upd_taken_in),
        .bpu_valid_out      (bpu_valid_out),
        .bpu_prediction_out (bpu_prediction_out),
        .bpu_idx_out        (bpu_idx_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain integer counters and history.
    int m_pht [N];
    int m_ghr;
    int m_v, m_p, m_idx;

    typedef struct {
        bit          rst;
        bit          req;
        logic [31:0] pc;
        bit          stall;
        bit          uv;
        int          uidx;
        bit          ut;
        int          ev;
        int          ep;
        int          ei;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit rst, input bit req, input logic [31:0] pc, input bit stall,
                       input bit uv, input int uidx, input bit ut,
                       input int ev, input int ep, input int ei);
        vec_t v;
        v.rst = rst; v.req = req; v.pc = pc; v.stall = stall;
        v.uv = uv; v.uidx = uidx; v.ut = ut;
        v.ev = ev; v.ep = ep; v.ei = ei;
        vt.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit req, input logic [31:0] pc, input bit stall,
                         input bit uv, input int uidx, input bit ut);
        rst_in           = rst;
        bpu_req_valid_in = req;
        bpu_pc_in        = pc;
        bpu_stall_in     = stall;
        bpu_upd_valid_in = uv;
        bpu_upd_idx_in   = IB'(uidx);
        bpu_upd_taken_in = ut;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_edge();
        int li;
        int post [N];
        if (!rst_in) begin
            foreach (m_pht[i]) m_pht[i] = 1;
            m_ghr = 0;
            m_v = 0; m_p = 0; m_idx = 0;
            return;
        end
        li = (int'(bpu_pc_in) >>> 2) & (N - 1);
`ifdef BPU_GSHARE_EN
        li = li ^ m_ghr;
`endif
        post = m_pht;
        if (bpu_upd_valid_in) begin
            if (bpu_upd_taken_in) post[bpu_upd_idx_in] = (m_pht[bpu_upd_idx_in] < 3) ? m_pht[bpu_upd_idx_in] + 1 : 3;
            else                  post[bpu_upd_idx_in] = (m_pht[bpu_upd_idx_in] > 0) ? m_pht[bpu_upd_idx_in] - 1 : 0;
`ifdef BPU_GSHARE_EN
            m_ghr = ((m_ghr * 2) + int'(bpu_upd_taken_in)) % N;
`endif
        end
        if (!bpu_stall_in) begin
            m_v   = int'(bpu_req_valid_in);
            m_idx = li;
            m_p   = (bpu_req_valid_in && post[li] >= 2) ? 1 : 0;
        end
        m_pht = post;
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        foreach (m_pht[i]) m_pht[i] = 1;
        m_ghr = 0; m_v = 0; m_p = 0; m_idx = 0;
        @(negedge clk_in);

`ifndef BPU_GSHARE_EN
        //  rst req pc            stall uv uidx ut   ev ep ei
        add(0, 1, 32'h10,        0, 1, 4, 1,  0, 0, 0);   // reset wins over request and update
        add(1, 1, 32'h10,        0, 0, 0, 0,  1, 0, 4);   // first lookup after reset
        add(1, 1, 32'h10,        0, 1, 4, 1,  1, 1, 4);   // bypass 01 -> 10
        add(1, 0, 32'h20,        0, 1, 4, 1,  0, 0, 8);   // -> 11
        add(1, 1, 32'h10,        0, 1, 4, 1,  1, 1, 4);   // saturates at 11
        add(1, 1, 32'h10,        0, 1, 4, 0,  1, 1, 4);   // -> 10
        add(1, 1, 32'h10,        0, 1, 4, 0,  1, 0, 4);   // -> 01
        add(1, 0, 32'h20,        0, 1, 4, 1,  0, 0, 8);   // -> 10
        add(1, 0, 32'h40,        1, 1, 4, 1,  0, 0, 8);   // stalled, -> 11
        add(1, 1, 32'h44,        1, 0, 0, 0,  0, 0, 8);   // stalled with request
        add(1, 0, 32'h48,        1, 1, 4, 0,  0, 0, 8);   // stalled, -> 10
        add(1, 1, 32'h10,        0, 0, 0, 0,  1, 1, 4);   // release sees stalled updates
        add(1, 0, 32'h0,         0, 1, 4, 1,  0, 0, 0);   // -> 11
        add(0, 1, 32'h10,        0, 1, 4, 1,  0, 0, 0);   // mid-stream reset
        add(1, 1, 32'h10,        0, 0, 0, 0,  1, 0, 4);   // counter back to 01
        add(1, 1, 32'h1FC,       0, 0, 0, 0,  1, 0, 63);  // top index
        add(1, 1, 32'hFFFF_FF04, 0, 1, 1, 1,  1, 1, 1);   // high PC bits ignored, bypass idx 1
        add(1, 1, 32'h10,        0, 1, 5, 1,  1, 0, 4);   // update elsewhere leaves idx 4 alone

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].req, vt[i].pc, vt[i].stall, vt[i].uv, vt[i].uidx, vt[i].ut);
            tick();
            check($sformatf("vec%0d_valid", i), 32'(bpu_valid_out),      vt[i].ev);
            check($sformatf("vec%0d_pred", i),  32'(bpu_prediction_out), vt[i].ep);
            check($sformatf("vec%0d_idx", i),   32'(bpu_idx_out),        vt[i].ei);
        end
`else
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("gs_reset_valid", 32'(bpu_valid_out), 0);
        check("gs_reset_idx",   32'(bpu_idx_out),   0);
        drive(1, 0, 0, 0, 1, 0, 1);
        tick();
        drive(1, 1, 32'h10, 0, 1, 0, 1);   // lookup uses history 1, not 3
        tick();
        check("gs_preupd_idx", 32'(bpu_idx_out), 5);
        drive(1, 1, 32'h10, 0, 0, 0, 0);
        tick();
        check("gs_valid", 32'(bpu_valid_out),      1);
        check("gs_idx",   32'(bpu_idx_out),        7);
        check("gs_pred",  32'(bpu_prediction_out), 0);
`endif

        // Randomized traffic with indices confined to a few entries to force collisions.
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] pc;
            pc = $urandom;
            pc[7:2] = 6'($urandom_range(0, 7));
            drive(($urandom_range(0, 63) != 0), $urandom_range(0, 1) == 1, pc,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 7), $urandom_range(0, 2) != 0);
            tick();
            check("rnd_valid", 32'(bpu_valid_out),      m_v);
            check("rnd_pred",  32'(bpu_prediction_out), m_p);
            check("rnd_idx",   32'(bpu_idx_out),        m_idx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
